regfile_dump: RTL
=================

# regfile_dump

Debug/verification reader for the 32×64 CPU register file. On a start pulse it sweeps the register file's combinational read port over X0..X(N_REGS-1). It snapshots each value and streams it out as (index, data) beats over a valid/ready interface. It sits beside the datapath, sharing one regfile read port with the pipeline, and is used only while the core is halted or in test.

## Interface
Parameters:
- N_REGS, 32, number of registers swept, starting from X0 (legal range 1..32).
- W, 64, register data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- start  in  1  request a dump; sampled only in IDLE.
- ra  out  5  read address driven to the regfile read port.
- rd  in  W  read data from the regfile read port (combinational w.r.t. ra).
- dump_valid  out  1  beat available.
- dump_ready  in  1  consumer accepts the beat.
- dump_idx  out  5  register number of the current beat.
- dump_data  out  W  captured register value of the current beat.
- busy  out  1  high in READ or SEND.
- done  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- FSM states: IDLE, READ, SEND, DONE. Internal 5-bit index counter idx.
- Reset (async, any state): state=IDLE, idx=0, ra=0, dump_valid=0, dump_idx=0, dump_data=0, busy=0, done=0.
- IDLE:
  - ra=0.
  - start=1 at an edge: idx←0, go to READ.
  - start=0: stay in IDLE.
- READ:
  - ra=idx.
  - At the next edge: dump_data←rd, dump_idx←idx, go to SEND.
  - Exactly one cycle in this state.
- SEND:
  - dump_valid=1. dump_idx and dump_data are held stable until the handshake.
  - ra is held at idx. Regfile writes after capture do not alter dump_data.
  - Handshake (dump_valid & dump_ready at an edge), with idx==N_REGS-1: go to DONE.
  - Handshake otherwise: idx←idx+1, go to READ.
  - No handshake: stay in SEND.
- DONE:
  - done=1 for exactly this cycle, dump_valid=0. Go to IDLE at the next edge.
- start outside IDLE is ignored. Queuing is not supported. start held high in IDLE after DONE launches a new dump.
- X31 (XZR) is read like any other register. Its value is whatever the regfile returns, which must be 0.
- idx never wraps: the terminal compare at N_REGS-1 precedes the increment. With N_REGS=32, idx reaches 31 and is never incremented.
- dump_valid must never drop without a handshake, except on reset.

## Timing
- Let E0 be the edge sampling start in IDLE.
- Read of register k happens in the cycle after E(2k). The beat for k is valid after E(2k+1).
- With dump_ready tied high: one beat per 2 cycles. The last handshake is at E(2·N_REGS); done is high in the following cycle; IDLE follows at E(2·N_REGS+1).
- Each cycle of dump_ready low in SEND adds one cycle of latency.
- busy rises after E0 and falls when entering DONE, so busy=0 while done=1.
- All outputs are registered or decoded from state. None depends combinationally on dump_ready or start.

## Test plan
In every scenario the regfile holds Xi=i for i=0..30 and X31=0.
- Reset: assert reset mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
- Full dump with dump_ready=1 and a start pulse at E0:
  - 32 beats (idx 0..31, data 0..30 then 0).
  - Beat k valid exactly during cycles after E(2k+1).
  - done high only in the cycle after E64; busy low from then on.
- Backpressure: drop dump_ready for 5 cycles while beat idx=3 is valid -> dump_valid stays 1 with idx=3 and data=3 stable. Writing 99 to X3 during the stall leaves dump_data=3. Total completion is delayed by 5 cycles.
- start pulsed at idx=7 mid-dump -> ignored. Sequence continues 8..31 with a single done pulse.
- Reset at idx=10 in SEND, then start -> dump_valid/busy drop asynchronously, no done pulse. The new dump begins at idx=0.
- N_REGS=4 instance, dump_ready=1 -> beats idx 0..3 with data 0..3. done is high in the cycle after E8.

Source files
------------

// File: rtl/regfile_dump.sv
// Register-file dump engine: sweeps the shared read port over X0..X(N_REGS-1)
// and streams each captured value out as an (index, data) valid/ready beat.
module regfile_dump #(
  parameter int unsigned N_REGS = 32,
  parameter int unsigned W      = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic [4:0]   ra,
  input  logic [W-1:0] rd,
  output logic         dump_valid,
  input  logic         dump_ready,
  output logic [4:0]   dump_idx,
  output logic [W-1:0] dump_data,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

  localparam logic [4:0] LastIdx = 5'(N_REGS - 1);

  state_e         state_q, state_d;
  logic [4:0]     idx_q, idx_d;
  logic [4:0]     dump_idx_q;
  logic [W-1:0]   dump_data_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          idx_d   = '0;
          state_d = StRead;
        end
      end
      StRead: state_d = StSend;
      StSend: begin
        if (dump_ready) begin
          // Terminal compare comes first so idx never wraps past the last register.
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = StRead;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      dump_idx_q  <= '0;
      dump_data_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == StRead) begin
        dump_idx_q  <= idx_q;
        dump_data_q <= rd;
      end
    end
  end

  // Outputs decode state only, so none depends combinationally on dump_ready or start.
  assign ra         = (state_q == StRead || state_q == StSend) ? idx_q : 5'd0;
  assign dump_valid = (state_q == StSend);
  assign busy       = (state_q == StRead || state_q == StSend);
  assign done       = (state_q == StDone);
  assign dump_idx   = dump_idx_q;
  assign dump_data  = dump_data_q;

endmodule
